// File: rtl/sent_pkg.sv
// Shared SENT transmit definitions: frame-controller state encoding, frame
// geometry and the CRC4 constants used by the checksum generator.
package sent_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_STATUS = 3'd2,
        ST_DATA   = 3'd3,
        ST_CRC    = 3'd4,
        ST_PAUSE  = 3'd5
    } state_e;

    // Number of data nibbles carried by one frame.
    localparam int         NUM_DATA_NIBBLES = 6;
    localparam logic [2:0] LAST_DATA_IDX    = 3'(NUM_DATA_NIBBLES - 1);

    // SENT CRC4: polynomial x^4+x^3+x^2+1, seed 4'b0101.
    localparam logic [3:0] CRC_SEED = 4'b0101;

    // CRC table T[i] = (i * x^4) mod poly.
    function automatic logic [3:0] crc4_tab(input logic [3:0] c);
        logic [3:0] t;
        case (c)
            4'd0:    t = 4'd0;
            4'd1:    t = 4'd13;
            4'd2:    t = 4'd7;
            4'd3:    t = 4'd10;
            4'd4:    t = 4'd14;
            4'd5:    t = 4'd3;
            4'd6:    t = 4'd9;
            4'd7:    t = 4'd4;
            4'd8:    t = 4'd1;
            4'd9:    t = 4'd12;
            4'd10:   t = 4'd6;
            4'd11:   t = 4'd11;
            4'd12:   t = 4'd15;
            4'd13:   t = 4'd2;
            4'd14:   t = 4'd8;
            default: t = 4'd5;
        endcase
        return t;
    endfunction

    // Data nibble selected by idx; idx 0 is the most significant nibble.
    function automatic logic [3:0] nibble_at(input logic [23:0] d, input logic [2:0] i);
        logic [3:0] n;
        case (i)
            3'd0:    n = d[23:20];
            3'd1:    n = d[19:16];
            3'd2:    n = d[15:12];
            3'd3:    n = d[11:8];
            3'd4:    n = d[7:4];
            3'd5:    n = d[3:0];
            default: n = 4'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sent_crc4.sv
// Combinational SENT CRC4 over the six data nibbles (status nibble excluded),
// table-driven with a final zero-nibble augmentation step.
module sent_crc4
    import sent_pkg::*;
(
    input  logic [23:0] data_i,
    output logic [3:0]  crc_o
);

    logic [3:0] c;

    // Fold the nibbles MSB-first through the table, then augment with zero.
    always_comb begin
        c = CRC_SEED;
        for (int i = 0; i < NUM_DATA_NIBBLES; i++) begin
            c = crc4_tab(c) ^ nibble_at(data_i, 3'(i));
        end
        crc_o = crc4_tab(c);
    end

endmodule

// File: rtl/sent_tx_frame_ctrl.sv
// SENT transmit frame controller: sequences sync, status, six data nibbles,
// CRC and an optional pause pulse, handing each pulse type and nibble value to
// an external pulse generator and advancing on its pulse_done.
module sent_tx_frame_ctrl
    import sent_pkg::*;
(
    input  logic        ticks,
    input  logic        reset_tx_n,
    input  logic [23:0] data_in,
    input  logic [3:0]  status_in,
    input  logic        pause_en,
    input  logic        data_valid,
    output logic        data_ready,
    input  logic        pulse_done,
    output logic        sync,
    output logic        pulse,
    output logic        pause,
    output logic        idle,
    output logic [3:0]  data_nibble,
    output logic        frame_done
);

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [23:0] data_q, data_d;
    logic [3:0]  status_q, status_d;
    logic        pause_en_q, pause_en_d;
    logic [3:0]  crc_q, crc_d;
    logic [3:0]  crc_calc;
    logic        sync_q, sync_d;
    logic        pulse_q, pulse_d;
    logic        pause_q, pause_d;
    logic        idle_q, idle_d;
    logic [3:0]  nibble_q, nibble_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic        accept;
    logic        end_frame;

    sent_crc4 u_crc (
        .data_i (data_in),
        .crc_o  (crc_calc)
    );

    // Next-state, frame latch and registered-output decode.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        data_d     = data_q;
        status_d   = status_q;
        pause_en_d = pause_en_q;
        crc_d      = crc_q;
        ready_d    = 1'b0;
        done_d     = 1'b0;
        accept     = 1'b0;
        end_frame  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // pulse_done has no meaning here; only a request starts a frame.
                if (data_valid) accept = 1'b1;
            end
            ST_SYNC: begin
                if (pulse_done) state_d = ST_STATUS;
            end
            ST_STATUS: begin
                if (pulse_done) begin
                    state_d = ST_DATA;
                    idx_d   = 3'd0;
                end
            end
            ST_DATA: begin
                if (pulse_done) begin
                    if (idx_q == LAST_DATA_IDX) begin
                        state_d = ST_CRC;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_CRC: begin
                if (pulse_done) begin
                    if (pause_en_q) state_d = ST_PAUSE;
                    else            end_frame = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (pulse_done) end_frame = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // A pending request at end of frame chains straight into the next sync.
        if (end_frame) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
            if (data_valid) accept = 1'b1;
        end

        if (accept) begin
            state_d    = ST_SYNC;
            idx_d      = 3'd0;
            data_d     = data_in;
            status_d   = status_in;
            pause_en_d = pause_en;
            crc_d      = crc_calc;
            ready_d    = 1'b1;
        end

        // Selects and nibble follow the state being entered so they are
        // registered and stay put until the next pulse_done.
        sync_d   = (state_d == ST_SYNC);
        pause_d  = (state_d == ST_PAUSE);
        idle_d   = (state_d == ST_IDLE);
        pulse_d  = (state_d == ST_STATUS) || (state_d == ST_DATA) || (state_d == ST_CRC);
        nibble_d = 4'd0;
        case (state_d)
            ST_STATUS: nibble_d = status_d;
            ST_DATA:   nibble_d = nibble_at(data_d, idx_d);
            ST_CRC:    nibble_d = crc_d;
            default:   nibble_d = 4'd0;
        endcase
    end

    // State, latched frame and output registers.
    always_ff @(posedge ticks or negedge reset_tx_n) begin
        if (!reset_tx_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= 3'd0;
            data_q     <= 24'd0;
            status_q   <= 4'd0;
            pause_en_q <= 1'b0;
            crc_q      <= 4'd0;
            sync_q     <= 1'b0;
            pulse_q    <= 1'b0;
            pause_q    <= 1'b0;
            idle_q     <= 1'b1;
            nibble_q   <= 4'd0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            status_q   <= status_d;
            pause_en_q <= pause_en_d;
            crc_q      <= crc_d;
            sync_q     <= sync_d;
            pulse_q    <= pulse_d;
            pause_q    <= pause_d;
            idle_q     <= idle_d;
            nibble_q   <= nibble_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
        end
    end

    assign sync        = sync_q;
    assign pulse       = pulse_q;
    assign pause       = pause_q;
    assign idle        = idle_q;
    assign data_nibble = nibble_q;
    assign data_ready  = ready_q;
    assign frame_done  = done_q;

endmodule

// File: tb/tb_sent_tx_frame_ctrl.sv
// Bench for sent_tx_frame_ctrl: table of frames with scoreboard of expected
// pulses, plus hand-written back-to-back, reset-abort and idle sequences.
module tb_sent_tx_frame_ctrl;

    logic        ticks = 1'b0;
    logic        reset_tx_n;
    logic [23:0] data_in;
    logic [3:0]  status_in;
    logic        pause_en;
    logic        data_valid;
    logic        data_ready;
    logic        pulse_done;
    logic        sync, pulse, pause, idle;
    logic [3:0]  data_nibble;
    logic        frame_done;

    always #5 ticks = ~ticks;

    sent_tx_frame_ctrl dut (
        .ticks       (ticks),
        .reset_tx_n  (reset_tx_n),
        .data_in     (data_in),
        .status_in   (status_in),
        .pause_en    (pause_en),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .pulse_done  (pulse_done),
        .sync        (sync),
        .pulse       (pulse),
        .pause       (pause),
        .idle        (idle),
        .data_nibble (data_nibble),
        .frame_done  (frame_done)
    );

    typedef struct {
        logic [3:0] sel;   // {sync, pulse, pause, idle}
        logic [3:0] nib;
    } pulse_t;

    typedef struct {
        logic [23:0] data;
        logic [3:0]  status;
        logic        pen;
        logic [3:0]  crc;
        int          gap;
    } vec_t;

    pulse_t     exp_q[$];
    vec_t       vecs[5];
    logic [3:0] tab[16];
    int total = 0;
    int bad = 0;
    int rdy_cnt = 0;
    int done_cnt = 0;
    int frames_exp = 0;

    // Strobe counters sample pre-edge values, so each one-tick strobe counts once.
    always @(posedge ticks) begin
        if (data_ready) rdy_cnt++;
        if (frame_done) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish required finish");
        $fatal(1, "watchdog");
    end

    task automatic report(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        report(nm, {31'd0, act}, {31'd0, exp});
    endtask

    task automatic chk4(input string nm, input logic [3:0] act, input logic [3:0] exp);
        report(nm, {28'd0, act}, {28'd0, exp});
    endtask

    task automatic chkn(input string nm, input int act, input int exp);
        report(nm, act, exp);
    endtask

    // CRC table built by polynomial reduction of i*x^4 modulo x^4+x^3+x^2+1.
    function automatic void build_tab();
        for (int i = 0; i < 16; i++) begin
            logic [7:0] v;
            v = 8'(i) << 4;
            for (int b = 7; b >= 4; b--) begin
                if (v[b]) v = v ^ (8'h1D << (b - 4));
            end
            tab[i] = v[3:0];
        end
    endfunction

    function automatic logic [3:0] model_crc(input logic [23:0] d);
        logic [3:0] c;
        c = 4'b0101;
        for (int i = 0; i < 6; i++) c = tab[c] ^ d[23 - 4*i -: 4];
        return tab[c];
    endfunction

    task automatic push_frame(input logic [23:0] d, input logic [3:0] s, input logic p,
                              input logic [3:0] crc);
        exp_q.push_back('{4'b1000, 4'h0});
        exp_q.push_back('{4'b0100, s});
        for (int i = 0; i < 6; i++) exp_q.push_back('{4'b0100, d[23 - 4*i -: 4]});
        exp_q.push_back('{4'b0100, crc});
        if (p) exp_q.push_back('{4'b0010, 4'h0});
    endtask

    task automatic check_pulse();
        pulse_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard: got pulse sel=%b required no pulse", {sync, pulse, pause, idle});
        end else begin
            e = exp_q.pop_front();
            chk4("select", {sync, pulse, pause, idle}, e.sel);
            chk4("nibble", data_nibble, e.nib);
        end
    endtask

    // Called at a negedge with the current pulse visible; returns at the
    // negedge after the edge that consumed pulse_done.
    task automatic do_pulse(input int gap);
        repeat (gap) @(negedge ticks);
        pulse_done = 1'b1;
        @(negedge ticks);
        pulse_done = 1'b0;
    endtask

    task automatic run_frame(input logic [23:0] d, input logic [3:0] s, input logic p,
                             input logic [3:0] crc, input int gap, input bit already,
                             input bit hold_next, input logic [23:0] nd,
                             input logic [3:0] ns, input logic np);
        int n;
        n = p ? 10 : 9;
        push_frame(d, s, p, crc);
        frames_exp++;
        if (!already) begin
            data_in    = d;
            status_in  = s;
            pause_en   = p;
            data_valid = 1'b1;
            @(negedge ticks);
        end
        chk1("data_ready", data_ready, 1'b1);
        if (hold_next) begin
            data_in   = nd;
            status_in = ns;
            pause_en  = np;
        end else begin
            data_valid = 1'b0;
            data_in    = 24'($urandom);
            status_in  = 4'($urandom);
            pause_en   = ~p;
        end
        for (int k = 0; k < n; k++) begin
            check_pulse();
            if (k > 0) chk1("frame_done_early", frame_done, 1'b0);
            do_pulse(gap);
        end
        chk1("frame_done", frame_done, 1'b1);
        if (!hold_next) begin
            chk1("idle_at_end", idle, 1'b1);
            @(negedge ticks);
            chk1("frame_done_len", frame_done, 1'b0);
            chk1("idle_after", idle, 1'b1);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk1({tag, "_idle"}, idle, 1'b1);
        chk4({tag, "_sel"}, {sync, pulse, pause}, 4'h0);
        chk4({tag, "_nibble"}, data_nibble, 4'h0);
        chk1({tag, "_ready"}, data_ready, 1'b0);
        chk1({tag, "_done"}, frame_done, 1'b0);
    endtask

    initial begin
        int r0;
        int d0;
        logic [23:0] rd;

        build_tab();
        vecs[0] = '{24'h000000, 4'h0, 1'b0, 4'h5, 1};
        vecs[1] = '{24'h123456, 4'hA, 1'b0, 4'h2, 0};
        vecs[2] = '{24'hFFFFFF, 4'h5, 1'b1, 4'hA, 2};
        vecs[3] = '{24'hABCDEF, 4'h3, 1'b0, 4'h7, 1};
        vecs[4] = '{24'h800001, 4'hF, 1'b1, 4'h6, 0};

        reset_tx_n = 1'b0;
        data_in    = 24'h0;
        status_in  = 4'h0;
        pause_en   = 1'b0;
        data_valid = 1'b0;
        pulse_done = 1'b0;

        @(negedge ticks);
        chk_reset_vals("reset");
        reset_tx_n = 1'b1;
        @(negedge ticks);
        chk_reset_vals("post_reset");

        // Table of frames with mid-frame input scrambling.
        for (int v = 0; v < 5; v++) begin
            run_frame(vecs[v].data, vecs[v].status, vecs[v].pen, vecs[v].crc,
                      vecs[v].gap, 1'b0, 1'b0, 24'h0, 4'h0, 1'b0);
        end

        // Random frames checked against the polynomial-derived model.
        for (int v = 0; v < 2; v++) begin
            rd = 24'($urandom);
            run_frame(rd, 4'($urandom), v[0], model_crc(rd), 1, 1'b0, 1'b0, 24'h0, 4'h0, 1'b0);
        end

        // pulse_done while idle must not start anything.
        pulse_done = 1'b1;
        repeat (3) @(negedge ticks);
        pulse_done = 1'b0;
        chk_reset_vals("idle_pulse_done");

        // Back-to-back frames with data_valid held across the boundary.
        r0 = rdy_cnt;
        run_frame(24'h13579B, 4'h6, 1'b0, model_crc(24'h13579B), 1, 1'b0, 1'b1,
                  24'h2468AC, 4'h9, 1'b1);
        chk1("b2b_sync", sync, 1'b1);
        chk1("b2b_no_idle", idle, 1'b0);
        run_frame(24'h2468AC, 4'h9, 1'b1, model_crc(24'h2468AC), 1, 1'b1, 1'b0,
                  24'h0, 4'h0, 1'b0);
        chkn("b2b_ready_count", rdy_cnt - r0, 2);

        // Reset during DATA idx=3 aborts the frame without frame_done.
        d0 = done_cnt;
        push_frame(24'hC0FFEE, 4'h1, 1'b0, model_crc(24'hC0FFEE));
        data_in    = 24'hC0FFEE;
        status_in  = 4'h1;
        data_valid = 1'b1;
        @(negedge ticks);
        data_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check_pulse();
            do_pulse(1);
        end
        check_pulse();
        #2;
        reset_tx_n = 1'b0;
        #1;
        chk_reset_vals("abort");
        exp_q.delete();
        repeat (2) @(negedge ticks);
        reset_tx_n = 1'b1;
        repeat (3) @(negedge ticks);
        chkn("abort_no_done", done_cnt - d0, 0);
        chk_reset_vals("abort_after");

        // Restart after abort.
        run_frame(24'h123456, 4'hA, 1'b1, 4'h2, 1, 1'b0, 1'b0, 24'h0, 4'h0, 1'b0);

        repeat (2) @(negedge ticks);
        chkn("frame_done_count", done_cnt, frames_exp);
        chkn("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sent_tx_frame_ctrl.md
SENT_TX_FRAME_CTRL -- requirements
Module: sent_tx_frame_ctrl

Interface
REQ-001 SHALL have port ticks, input, 1: single clock; all state changes on posedge ticks.
REQ-002 SHALL have port reset_tx_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port data_in, input, 24: six data nibbles; data_in[23:20] is sent first.
REQ-004 SHALL have port status_in, input, 4: status/communication nibble.
REQ-005 SHALL have port pause_en, input, 1: append a pause pulse to the frame.
REQ-006 SHALL have port data_valid, input, 1: frame request; held high until accepted.
REQ-007 SHALL have port data_ready, output, 1: one-tick accept strobe for data_valid.
REQ-008 SHALL have port pulse_done, input, 1: pulse-generator completion, sampled at posedge.
REQ-009 SHALL have ports sync, pulse, pause and idle, each output, 1: generator pulse-type selects.
REQ-010 SHALL have port data_nibble, output, 4: nibble value for the current pulse.
REQ-011 SHALL have port frame_done, output, 1: one-tick strobe after the last pulse of a frame.

Function
REQ-012 SHALL implement states IDLE, SYNC, STATUS, DATA, CRC and PAUSE, with a 3-bit nibble index idx (0..5) used in DATA.
REQ-013 SHALL keep sync, pulse, pause and idle one-hot, registered and held constant until the pulse_done that ends the current pulse.
- idle=1 in IDLE; sync=1 in SYNC; pause=1 in PAUSE.
- pulse=1 in STATUS, DATA and CRC.
REQ-014 SHALL, in IDLE with data_valid=1, register data_in, status_in, pause_en and the computed CRC, pulse data_ready for one tick and enter SYNC on the next tick.
REQ-015 SHALL ignore pulse_done in IDLE.
REQ-016 SHALL advance only on a tick where pulse_done=1:
- SYNC->STATUS;
- STATUS->DATA with idx=0;
- DATA with idx<5 -> DATA with idx+1;
- DATA with idx=5 -> CRC;
- CRC->PAUSE if the latched pause_en=1, otherwise end of frame;
- PAUSE->end of frame.
REQ-017 SHALL drive data_nibble as follows:
- latched status in STATUS;
- latched data[23-4*idx -: 4] in DATA;
- latched CRC in CRC;
- 0 in IDLE, SYNC and PAUSE.
REQ-018 SHALL, at end of frame, pulse frame_done for one tick.
REQ-019 SHALL, at end of frame, go directly to SYNC if data_valid=1, performing the latch and data_ready strobe of REQ-014 on that same tick with no idle pulse in between; otherwise it SHALL go to IDLE.
REQ-020 SHALL compute the CRC as SENT CRC4 over the six data nibbles only (status nibble excluded):
- polynomial x^4+x^3+x^2+1, seed 4'b0101;
- per nibble: c = T[c] ^ nibble, where T[i] = (i*x^4) mod poly;
- final augmentation: c = T[c] ^ 0.
REQ-021 SHALL hold data_in, status_in and pause_en changes made mid-frame with no effect until the next accept.
REQ-022 SHALL apply a pulse_done coincident with any state entry to the state being left; no pulse is skipped.

Reset
REQ-023 SHALL, while reset_tx_n=0, force state=IDLE, idx=0, idle=1, sync=pulse=pause=0, data_nibble=0, data_ready=0, frame_done=0 and latched registers=0.
REQ-024 SHALL abort a frame in progress on reset, with no frame_done, and restart from IDLE after deassertion.

Structure
REQ-025 SHALL place the state encoding, the frame length constant (6 data nibbles), the CRC seed and the CRC table in the shared SENT package.
REQ-026 SHALL implement the CRC in the combinational sub-module sent_crc4 (24-bit data in, 4-bit CRC out), instantiated once.

Verification
REQ-027 SHALL cover: data_in=24'h000000, status_in=0, pause_en=0, with pulse_done given one tick after each select -> select order sync, pulse x8; nibbles 0,0,0,0,0,0,0,5; frame_done once; then idle.
REQ-028 SHALL cover: data_in=24'h123456, status_in=4'hA -> nibbles A,1,2,3,4,5,6 then the CRC matching the table model.
REQ-029 SHALL cover: pause_en=1 -> pause=1 after the CRC pulse and frame_done only after the pause pulse_done.
REQ-030 SHALL cover: data_valid held high across two frames -> second sync on the tick after the first frame_done, no idle, and exactly two data_ready strobes.
REQ-031 SHALL cover: reset_tx_n low during DATA idx=3 -> outputs at reset values immediately, with no frame_done.
REQ-032 SHALL cover: pulse_done pulsed in IDLE, and data_in changed mid-frame -> no state change, and transmitted nibbles equal the latched values.
